// File: rtl/vga_pixel_write_ctrl_if.sv
// ============================================================================
// Module   : vga_pixel_write_ctrl_if
// Brief    : HPS PIO request side and Avalon-MM frame-buffer write side of
//            the VGA pixel write controller, plus its status outputs.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vga_pixel_write_ctrl_if #(
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]  pio_addr;
  logic [COLOR_W-1:0] pio_color;
  logic               pio_req;
  logic               pio_ack;
  logic [ADDR_W-1:0]  sram_address;
  logic [COLOR_W-1:0] sram_writedata;
  logic               sram_write;
  logic               sram_waitrequest;
  logic [LVL_W-1:0]   fifo_level;
  logic [15:0]        drop_count;
  logic               busy;

  // Controller view
  modport slave (
    input  pio_addr, pio_color, pio_req, sram_waitrequest,
    output pio_ack, sram_address, sram_writedata, sram_write,
           fifo_level, drop_count, busy
  );

  // HPS / memory / monitor view
  modport master (
    output pio_addr, pio_color, pio_req, sram_waitrequest,
    input  pio_ack, sram_address, sram_writedata, sram_write,
           fifo_level, drop_count, busy
  );
endinterface

`default_nettype wire

// File: rtl/vga_pixel_write_ctrl.sv
// ============================================================================
// Module   : vga_pixel_write_ctrl
// Brief    : Turns HPS PIO request toggles into ordered Avalon-MM pixel writes
//            through a small FIFO; out-of-frame addresses are dropped/counted.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_pixel_write_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_ADDR   = 307200
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_pixel_write_ctrl_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + COLOR_W;
  localparam logic [ADDR_W:0]  LIMIT     = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               ack_q, ack_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               wr_q, wr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [15:0]        drop_q, drop_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic               pending, in_range, fifo_empty, fifo_full;
  logic               pop, push, drop;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    ack_d    = ack_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    pop      = 1'b0;

    head       = mem_q[rd_ptr_q];
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == DEPTH_LVL);
    pending    = (bus.pio_req != req_q);
    in_range   = ({1'b0, bus.pio_addr} < LIMIT);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wr_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Chain the next queued pixel on the completing edge: no idle bubble
        if (!bus.sram_waitrequest) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            wr_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      addr_d   = head[ENTRY_W-1:COLOR_W];
      data_d   = head[COLOR_W-1:0];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // A slot freed by this edge's pop is usable by this edge's push
    push = pending && in_range && (!fifo_full || pop);
    drop = pending && !in_range;

    if (push || drop) begin
      req_d = bus.pio_req;
      ack_d = ~ack_q;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= bus.pio_req;
      ack_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {bus.pio_addr, bus.pio_color};
    end
  end

  assign bus.pio_ack        = ack_q;
  assign bus.sram_address   = addr_q;
  assign bus.sram_writedata = data_q;
  assign bus.sram_write     = wr_q;
  assign bus.fifo_level     = level_q;
  assign bus.drop_count     = drop_q;
  assign bus.busy           = (level_q != '0) | wr_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_write_ctrl.sv
// ============================================================================
// Module   : tb_vga_pixel_write_ctrl
// Brief    : Directed bench with a queue-based reference model for the VGA
//            pixel write controller.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_pixel_write_ctrl;

  localparam int ADDR_W     = 19;
  localparam int COLOR_W    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_ADDR   = 307200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_pixel_write_ctrl_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  vga_pixel_write_ctrl #(
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_ADDR(MAX_ADDR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pixels as a queue, one in-flight write slot
  typedef struct packed {
    logic [ADDR_W-1:0]  a;
    logic [COLOR_W-1:0] c;
  } pix_t;

  pix_t m_q[$];
  pix_t acc_q[$];
  pix_t m_cur, sb_e, m_px;
  bit   m_valid, m_ack, m_req, model_on, m_done, m_pop, m_push;
  int   m_drops;
  int   n_writes = 0;

  always @(posedge clk) begin
    if (model_on && !reset && bus.sram_write === 1'b1 && bus.sram_waitrequest == 1'b0) begin
      n_writes++;
      check("write_expected", (acc_q.size() != 0), 1);
      if (acc_q.size() != 0) begin
        sb_e = acc_q.pop_front();
        check("write_order", {bus.sram_address, bus.sram_writedata}, sb_e);
      end
    end

    if (reset) begin
      m_q.delete();
      acc_q.delete();
      m_valid  = 1'b0;
      m_ack    = 1'b0;
      m_drops  = 0;
      m_req    = bus.pio_req;
      model_on = 1'b1;
    end else if (model_on) begin
      m_done = m_valid && !bus.sram_waitrequest;
      m_pop  = (m_q.size() > 0) && (!m_valid || m_done);
      m_push = 1'b0;
      if (bus.pio_req != m_req) begin
        if (bus.pio_addr >= MAX_ADDR) begin
          if (m_drops < 65535) m_drops++;
          m_req = bus.pio_req;
          m_ack = ~m_ack;
        end else if (m_q.size() < FIFO_DEPTH || m_pop) begin
          m_px   = '{a: bus.pio_addr, c: bus.pio_color};
          m_push = 1'b1;
          m_req  = bus.pio_req;
          m_ack  = ~m_ack;
        end
      end
      if (m_pop) begin
        m_cur   = m_q.pop_front();
        m_valid = 1'b1;
      end else if (m_done) begin
        m_valid = 1'b0;
      end
      if (m_push) begin
        m_q.push_back(m_px);
        acc_q.push_back(m_px);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("sram_write", bus.sram_write, m_valid);
      if (m_valid) begin
        check("sram_address", bus.sram_address, m_cur.a);
        check("sram_writedata", bus.sram_writedata, m_cur.c);
      end
      check("pio_ack", bus.pio_ack, m_ack);
      check("fifo_level", bus.fifo_level, m_q.size());
      check("drop_count", bus.drop_count, m_drops);
      check("busy", bus.busy, (m_q.size() != 0) || m_valid);
    end
  end

  // Stimulus helpers
  bit ack_exp;
  int wb;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int a, input int c);
    bus.pio_addr  = a[ADDR_W-1:0];
    bus.pio_color = c[COLOR_W-1:0];
    bus.pio_req   = ~bus.pio_req;
  endtask

  task automatic wait_ack(input int budget);
    int k = 0;
    ack_exp = ~ack_exp;
    while (bus.pio_ack !== ack_exp && k < budget) begin
      step(1);
      k++;
    end
    check("ack_arrival", bus.pio_ack, ack_exp);
  endtask

  task automatic send(input int a, input int c);
    issue(a, c);
    wait_ack(20);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    check("drain_idle", bus.busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.pio_req = 1'b0;
    bus.pio_addr = '0;
    bus.pio_color = '0;
    bus.sram_waitrequest = 1'b0;
    ack_exp = 1'b0;
    step(3);

    check("rst_ack", bus.pio_ack, 0);
    check("rst_write", bus.sram_write, 0);
    check("rst_addr", bus.sram_address, 0);
    check("rst_data", bus.sram_writedata, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_drops", bus.drop_count, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    step(1);

    // Single pixel: ack after 1 cycle, write visible after 2
    wb = n_writes;
    issue(1234, 'hE0);
    step(1);
    check("single_ack", bus.pio_ack, 1);
    ack_exp = 1'b1;
    step(1);
    check("single_write", bus.sram_write, 1);
    check("single_addr", bus.sram_address, 1234);
    check("single_data", bus.sram_writedata, 'hE0);
    step(1);
    check("single_write_done", bus.sram_write, 0);
    check("single_count", n_writes - wb, 1);
    check("single_busy", bus.busy, 0);

    // Out of range drops, then last valid address
    send(MAX_ADDR, 'h11);
    send(524287, 'h22);
    check("oor_drops", bus.drop_count, 2);
    check("oor_no_write", bus.sram_write, 0);
    check("oor_level", bus.fifo_level, 0);
    wb = n_writes;
    send(307199, 'h5A);
    step(1);
    check("edge_write", bus.sram_write, 1);
    check("edge_addr", bus.sram_address, 307199);
    step(2);
    check("edge_count", n_writes - wb, 1);

    // Back-pressure: 1 in flight + 4 queued, 6th held off
    bus.sram_waitrequest = 1'b1;
    wb = n_writes;
    for (int i = 0; i < 5; i++) send(1000 + i * 7, 'h30 + i);
    step(2);
    check("bp_level_full", bus.fifo_level, 4);
    check("bp_write", bus.sram_write, 1);
    check("bp_addr", bus.sram_address, 1000);
    issue(2000, 'hAB);
    step(5);
    check("bp_no_ack", bus.pio_ack, ack_exp);
    check("bp_level_hold", bus.fifo_level, 4);
    check("bp_stall_addr", bus.sram_address, 1000);
    check("bp_stall_data", bus.sram_writedata, 'h30);
    bus.sram_waitrequest = 1'b0;
    ack_exp = ~ack_exp;
    step(1);
    check("bp_late_ack", bus.pio_ack, ack_exp);
    check("bp_level_swap", bus.fifo_level, 4);
    check("bp_next_addr", bus.sram_address, 1007);
    wait_idle(30);
    check("bp_writes", n_writes - wb, 6);

    // Back-to-back drain of 4 pixels
    bus.sram_waitrequest = 1'b1;
    wb = n_writes;
    for (int i = 0; i < 4; i++) send(5000 + i * 3, 'h60 + i);
    step(2);
    check("b2b_level", bus.fifo_level, 3);
    bus.sram_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_write", bus.sram_write, 1);
      check("b2b_addr", bus.sram_address, 5000 + i * 3);
      step(1);
    end
    check("b2b_idle", bus.sram_write, 0);
    check("b2b_busy", bus.busy, 0);
    check("b2b_count", n_writes - wb, 4);

    // Reset in WRITE with 3 queued and pio_req high
    if (bus.pio_req == 1'b0) send(MAX_ADDR + 5, 0);
    bus.sram_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) send(7000 + i, 'h70 + i);
    step(1);
    check("mid_level", bus.fifo_level, 3);
    check("mid_write", bus.sram_write, 1);
    check("mid_req_high", bus.pio_req, 1);
    reset = 1'b1;
    step(1);
    check("mid_rst_write", bus.sram_write, 0);
    check("mid_rst_level", bus.fifo_level, 0);
    check("mid_rst_ack", bus.pio_ack, 0);
    check("mid_rst_busy", bus.busy, 0);
    reset = 1'b0;
    bus.sram_waitrequest = 1'b0;
    ack_exp = 1'b0;
    wb = n_writes;
    step(10);
    check("post_rst_writes", n_writes - wb, 0);
    check("post_rst_ack", bus.pio_ack, 0);
    check("post_rst_level", bus.fifo_level, 0);

    // drop_count saturation
    for (int i = 0; i < 65540; i++) begin
      issue(MAX_ADDR + (i % 1000), i);
      ack_exp = ~ack_exp;
      step(1);
      if (i == 999)   check("drop_1000", bus.drop_count, 1000);
      if (i == 65534) check("drop_reach_max", bus.drop_count, 'hFFFF);
    end
    check("drop_sat_hold", bus.drop_count, 'hFFFF);
    check("drop_sat_ack", bus.pio_ack, ack_exp);
    check("drop_sat_no_write", bus.sram_write, 0);
    step(2);
    check("all_accepted_written", acc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_pixel_write_ctrl.md
Name: vga_pixel_write_ctrl

Overview:
- Sits directly downstream of the HPS PIO registers that hold the VGA pixel address (19 bits), the pixel colour, and a request toggle.
- Turns each HPS request into exactly one Avalon-MM write into the VGA frame-buffer memory.
- Buffers requests in a small FIFO so software can issue pixels faster than the memory accepts them.
- Drops writes whose address falls outside the visible frame and counts them.

Parameters:
- ADDR_W, 19, pixel address width; matches the PIO address port.
- COLOR_W, 8, pixel colour width.
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, 2..16.
- MAX_ADDR, 307200, first invalid pixel address (640x480).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pio_addr  in  ADDR_W  pixel address from the HPS PIO.
- pio_color  in  COLOR_W  pixel colour from the HPS PIO.
- pio_req  in  1  request toggle; each level change is one request.
- pio_ack  out  1  acknowledge toggle back to an HPS PIO input.
- sram_address  out  ADDR_W  Avalon-MM master address.
- sram_writedata  out  COLOR_W  Avalon-MM master write data.
- sram_write  out  1  Avalon-MM master write strobe.
- sram_waitrequest  in  1  Avalon-MM slave stall.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  saturating count of out-of-range requests.
- busy  out  1  high when the FIFO is non-empty or a write is outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state is updated only on the rising edge of clk.
- Reset values: pio_ack=0, sram_write=0, sram_address=0, sram_writedata=0, fifo_level=0, drop_count=0, busy=0, FSM=IDLE, FIFO pointers=0.
- Internal req_q is loaded with pio_req on every reset cycle, so no phantom request appears after reset.
- Request detect: a request is pending when pio_req != req_q. No synchroniser is used; the PIO is on the same clock.
- In-range pending request (pio_addr < MAX_ADDR) with the FIFO not full, at a clock edge:
  - push {pio_addr, pio_color};
  - req_q <= pio_req;
  - pio_ack toggles.
  - pio_ack is therefore visible 1 cycle after pio_req changes.
- FIFO full: the request stays pending. There is no push, no ack toggle and no loss. It is accepted on the first edge where space exists, including the edge at which a pop frees a slot.
- Out-of-range request (pio_addr >= MAX_ADDR): not pushed; req_q updates; pio_ack toggles; drop_count increments, saturating at 16'hFFFF. The FIFO-full state does not block a drop.
- pio_addr and pio_color are sampled on the accepting edge only; software must hold them stable until ack.
- Drain FSM, IDLE state: if the FIFO is non-empty, load the head into sram_address/sram_writedata, pop, and go to WRITE.
- Drain FSM, WRITE state: sram_write=1, with address and data held stable.
  - On an edge with sram_waitrequest=0 the write completes.
  - If the FIFO is non-empty at that edge, load the next head, pop, and stay in WRITE (back-to-back writes, no bubble).
  - Otherwise sram_write<=0 and go to IDLE.
- Latency: request toggle to first sram_write assertion is 2 cycles when the FIFO is empty and the FSM is idle.
- sram_write is registered and never drops while sram_waitrequest=1.
- Simultaneous push and pop in one cycle: fifo_level is unchanged, and both operations take effect.
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- busy = (fifo_level != 0) | sram_write.
- Reset mid-write: sram_write drops on the reset edge, the FIFO is flushed, and in-flight and queued pixels are discarded.
- Write ordering: memory writes occur in request order.

Test Plan:
- Single pixel: after reset, pio_addr=1234, pio_color=8'hE0, toggle pio_req -> pio_ack toggles next cycle; sram_write=1 two cycles after the toggle with sram_address=1234 and sram_writedata=E0; one write only.
- Back-pressure: hold sram_waitrequest=1 while issuing 6 requests -> 1 in WRITE plus 4 in the FIFO; the 6th gets no ack toggle and fifo_level=4.
  - Then release waitrequest -> the 6th is accepted on the first pop edge.
  - All 6 addresses appear in order, with address and data stable while stalled.
- Out of range: pio_addr=307200 then 524287 -> two ack toggles, drop_count=2, no sram_write.
  - pio_addr=307199 -> written normally.
- Back-to-back: 4 queued requests, waitrequest=0 -> sram_write stays high 4 consecutive cycles with addresses in order; then IDLE and busy=0.
- Reset mid-operation: assert reset while in WRITE with 3 entries queued and pio_req=1 -> next cycle sram_write=0, fifo_level=0, pio_ack=0.
  - After reset deasserts, with pio_req held at 1 -> no write occurs.
- drop_count saturation: force 65536 out-of-range requests -> drop_count holds at FFFF.
